// File: rtl/ycr1_sleep_seq.sv
// Sleep/wake sequencer: turns a pipeline WFI into a drain / gate / wake / resume
// handshake with the pipe clock controller. Runs on the always-on clock.
module ycr1_sleep_seq #(
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter int unsigned WAKE_DLY      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wfi_req_i,
  input  logic        imem_busy_i,
  input  logic        dmem_busy_i,
  input  logic        irq_pending_i,
  input  logic        dbg_halt_req_i,
  input  logic        clk_en_i,
  output logic        sleep_req_o,
  output logic        wake_req_o,
  output logic        wfi_ack_o,
  output logic        wfi_abort_o,
  output logic [2:0]  state_o,
  output logic [31:0] sleep_cnt_o
);

  typedef enum logic [2:0] {
    StRun    = 3'd0,
    StDrain  = 3'd1,
    StReq    = 3'd2,
    StSleep  = 3'd3,
    StWake   = 3'd4,
    StResume = 3'd5
  } state_e;

  localparam logic [15:0] DrainLast = 16'(DRAIN_TIMEOUT - 1);
  localparam logic [3:0]  WakeDly   = 4'(WAKE_DLY);

  state_e      state_q, state_d;
  logic [15:0] drain_cnt_q, drain_cnt_d;
  logic [3:0]  resume_cnt_q, resume_cnt_d;
  logic [31:0] sleep_cnt_q, sleep_cnt_d;
  logic        sleep_req_q, sleep_req_d;
  logic        wake_req_q, wake_req_d;
  logic        wfi_ack_q, wfi_ack_d;
  logic        wfi_abort_q, wfi_abort_d;

  logic wake_evt;
  logic holdoff;

  assign wake_evt = irq_pending_i | dbg_halt_req_i;
  // A WFI still held in the cycle the pipe sees ack/abort must not restart the sequence.
  assign holdoff  = wfi_ack_q | wfi_abort_q;

  // Next-state, counters and registered output values.
  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    resume_cnt_d = resume_cnt_q;
    sleep_cnt_d  = sleep_cnt_q;
    wfi_ack_d    = 1'b0;
    wfi_abort_d  = 1'b0;

    case (state_q)
      StRun: begin
        // Clock found gated while running: recover it first.
        if (!clk_en_i) begin
          state_d = StWake;
        end else if (wfi_req_i && !holdoff) begin
          if (wake_evt) begin
            wfi_abort_d = 1'b1;
          end else begin
            state_d     = StDrain;
            drain_cnt_d = '0;
          end
        end
      end
      StDrain: begin
        if (wake_evt) begin
          wfi_abort_d = 1'b1;
          state_d     = StRun;
        end else if (!imem_busy_i && !dmem_busy_i) begin
          state_d = StReq;
        end else if (drain_cnt_q == DrainLast) begin
          wfi_abort_d = 1'b1;
          state_d     = StRun;
        end else begin
          drain_cnt_d = drain_cnt_q + 16'd1;
        end
      end
      StReq: begin
        // A wake here may race the gating; WAKE handles both outcomes.
        if (wake_evt) begin
          state_d = StWake;
        end else if (!clk_en_i) begin
          state_d = StSleep;
        end
      end
      StSleep: begin
        if (sleep_cnt_q != '1) begin
          sleep_cnt_d = sleep_cnt_q + 32'd1;
        end
        if (wake_evt) begin
          state_d = StWake;
        end
      end
      StWake: begin
        if (clk_en_i) begin
          state_d      = StResume;
          resume_cnt_d = WakeDly;
        end
      end
      StResume: begin
        if (resume_cnt_q == '0) begin
          state_d   = StRun;
          wfi_ack_d = 1'b1;
        end else begin
          resume_cnt_d = resume_cnt_q - 4'd1;
        end
      end
      default: state_d = StRun;
    endcase

    sleep_req_d = (state_d == StReq);
    wake_req_d  = (state_d == StWake);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StRun;
      drain_cnt_q  <= '0;
      resume_cnt_q <= '0;
      sleep_cnt_q  <= '0;
      sleep_req_q  <= 1'b0;
      wake_req_q   <= 1'b0;
      wfi_ack_q    <= 1'b0;
      wfi_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      resume_cnt_q <= resume_cnt_d;
      sleep_cnt_q  <= sleep_cnt_d;
      sleep_req_q  <= sleep_req_d;
      wake_req_q   <= wake_req_d;
      wfi_ack_q    <= wfi_ack_d;
      wfi_abort_q  <= wfi_abort_d;
    end
  end

  assign sleep_req_o = sleep_req_q;
  assign wake_req_o  = wake_req_q;
  assign wfi_ack_o   = wfi_ack_q;
  assign wfi_abort_o = wfi_abort_q;
  assign state_o     = state_q;
  assign sleep_cnt_o = sleep_cnt_q;

endmodule
